multicycle_control_unit: RTL and testbench

Sequential control FSM for the multi-cycle RV64 datapath. It drives fetch, decode, execute, memory and writeback phases over several clocks, sharing one ALU and one memory port. It decodes R-type, ld, sd, addi, SB-type and, optionally, jal. It waits on a memory-ready handshake, traps on illegal opcodes or memory timeout, and reports retirement.

---
 rtl/multicycle_control_unit.sv | 246 ++++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV64 control FSM: sequences fetch/decode/execute/memory/writeback,
// waits on the memory handshake with a timeout, and traps on bad opcodes or stalls.
module multicycle_control_unit #(
    parameter int unsigned OPCODE_W    = 7,
    parameter bit          ENABLE_JAL  = 1'b1,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] Opcode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic                IorD,
    output logic                IRWrite,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                MemtoReg,
    output logic                Regwrite,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          ALUOp,
    output logic                PCSource,
    output logic                illegal_instr,
    output logic                mem_fault,
    output logic                instr_retired,
    output logic [3:0]          state_o
);

    localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT);

    localparam logic [OPCODE_W-1:0] OP_RTYPE  = OPCODE_W'(7'b0110011);
    localparam logic [OPCODE_W-1:0] OP_ITYPE  = OPCODE_W'(7'b0010011);
    localparam logic [OPCODE_W-1:0] OP_LOAD   = OPCODE_W'(7'b0000011);
    localparam logic [OPCODE_W-1:0] OP_STORE  = OPCODE_W'(7'b0100011);
    localparam logic [OPCODE_W-1:0] OP_BRANCH = OPCODE_W'(7'b1100011);
    localparam logic [OPCODE_W-1:0] OP_JAL    = OPCODE_W'(7'b1101111);

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_BR   = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        WB_MEM   = 4'd4,
        MEM_WR   = 4'd5,
        EXEC_R   = 4'd6,
        EXEC_I   = 4'd7,
        WB_ALU   = 4'd8,
        BRANCH   = 4'd9,
        JUMP     = 4'd10,
        TRAP     = 4'd15
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_n, wait_cnt_inc;
    logic             ill_q, ill_n;
    logic             flt_q, flt_n;
    logic             waiting;
    logic             timed_out;

    // Branch resolution (PCWriteCond & zero) is done in the datapath.
    logic unused_zero;
    assign unused_zero = zero;

    // State, wait counter and sticky trap flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FETCH;
            wait_cnt <= '0;
            ill_q    <= 1'b0;
            flt_q    <= 1'b0;
        end else begin
            state    <= state_n;
            wait_cnt <= wait_cnt_n;
            ill_q    <= ill_n;
            flt_q    <= flt_n;
        end
    end

    assign waiting      = ((state == FETCH) || (state == MEM_RD) || (state == MEM_WR)) && !mem_ready;
    assign wait_cnt_inc = wait_cnt + CNT_W'(1);
    // mem_ready on the last allowed cycle wins, since waiting is then false.
    assign timed_out    = waiting && (wait_cnt_inc == CNT_LIMIT);

    // Next state and control strobes.
    always_comb begin
        state_n       = state;
        wait_cnt_n    = '0;
        ill_n         = ill_q;
        flt_n         = flt_q;
        PCWrite       = 1'b0;
        PCWriteCond   = 1'b0;
        IorD          = 1'b0;
        IRWrite       = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        MemtoReg      = 1'b0;
        Regwrite      = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = SRCB_RS2;
        ALUOp         = ALUOP_ADD;
        PCSource      = 1'b0;
        instr_retired = 1'b0;

        if (waiting) begin
            wait_cnt_n = wait_cnt_inc;
        end

        case (state)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_n = DECODE;
                end else if (timed_out) begin
                    flt_n   = 1'b1;
                    state_n = TRAP;
                end
            end
            DECODE: begin
                ALUSrcB = SRCB_IMM;
                case (Opcode)
                    OP_RTYPE:            state_n = EXEC_R;
                    OP_ITYPE:            state_n = EXEC_I;
                    OP_LOAD, OP_STORE:   state_n = MEM_ADDR;
                    OP_BRANCH:           state_n = BRANCH;
                    OP_JAL: begin
                        if (ENABLE_JAL) begin
                            state_n = JUMP;
                        end else begin
                            ill_n   = 1'b1;
                            state_n = TRAP;
                        end
                    end
                    default: begin
                        ill_n   = 1'b1;
                        state_n = TRAP;
                    end
                endcase
            end
            MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                state_n = (Opcode == OP_LOAD) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
                if (mem_ready) begin
                    state_n = WB_MEM;
                end else if (timed_out) begin
                    flt_n   = 1'b1;
                    state_n = TRAP;
                end
            end
            WB_MEM: begin
                Regwrite      = 1'b1;
                MemtoReg      = 1'b1;
                instr_retired = 1'b1;
                state_n       = FETCH;
            end
            MEM_WR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                if (mem_ready) begin
                    instr_retired = 1'b1;
                    state_n       = FETCH;
                end else if (timed_out) begin
                    flt_n   = 1'b1;
                    state_n = TRAP;
                end
            end
            EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_RS2;
                ALUOp   = ALUOP_FUNC;
                state_n = WB_ALU;
            end
            EXEC_I: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                state_n = WB_ALU;
            end
            WB_ALU: begin
                Regwrite      = 1'b1;
                instr_retired = 1'b1;
                state_n       = FETCH;
            end
            BRANCH: begin
                ALUSrcA       = 1'b1;
                ALUSrcB       = SRCB_RS2;
                ALUOp         = ALUOP_BR;
                PCWriteCond   = 1'b1;
                PCSource      = 1'b1;
                instr_retired = 1'b1;
                state_n       = FETCH;
            end
            JUMP: begin
                Regwrite      = 1'b1;
                PCWrite       = 1'b1;
                PCSource      = 1'b1;
                instr_retired = 1'b1;
                state_n       = FETCH;
            end
            TRAP: begin
                state_n = TRAP;
            end
            default: begin
                state_n = TRAP;
            end
        endcase

        // A cycle with reset asserted never issues strobes or a retire pulse.
        if (reset) begin
            PCWrite       = 1'b0;
            PCWriteCond   = 1'b0;
            IorD          = 1'b0;
            IRWrite       = 1'b0;
            MemRead       = 1'b0;
            MemWrite      = 1'b0;
            MemtoReg      = 1'b0;
            Regwrite      = 1'b0;
            ALUSrcA       = 1'b0;
            ALUSrcB       = SRCB_RS2;
            ALUOp         = ALUOP_ADD;
            PCSource      = 1'b0;
            instr_retired = 1'b0;
        end
    end

    assign illegal_instr = ill_q;
    assign mem_fault     = flt_q;
    assign state_o       = 4'(state);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized bench for multicycle_control_unit: expected per-cycle traces are planned
// per instruction from opcode class and memory latencies, then replayed against two DUTs.
module tb_multicycle_control_unit;

    localparam int T = 4;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam int S_FETCH = 0, S_DECODE = 1, S_MEM_ADDR = 2, S_MEM_RD = 3, S_WB_MEM = 4;
    localparam int S_MEM_WR = 5, S_EXEC_R = 6, S_EXEC_I = 7, S_WB_ALU = 8, S_BRANCH = 9;
    localparam int S_JUMP = 10, S_TRAP = 15;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic [6:0] Opcode = 7'd0;

    logic a_pcw, a_pcwc, a_iord, a_irw, a_mrd, a_mwr, a_m2r, a_rw, a_srca, a_pcsrc, a_ill, a_flt, a_ret;
    logic b_pcw, b_pcwc, b_iord, b_irw, b_mrd, b_mwr, b_m2r, b_rw, b_srca, b_pcsrc, b_ill, b_flt, b_ret;
    logic [1:0] a_srcb, a_aluop, b_srcb, b_aluop;
    logic [3:0] a_st, b_st;
    logic [16:0] va, vb;

    assign va = {a_pcw, a_pcwc, a_iord, a_irw, a_mrd, a_mwr, a_m2r, a_rw, a_srca, a_srcb, a_aluop, a_pcsrc, a_ill, a_flt, a_ret};
    assign vb = {b_pcw, b_pcwc, b_iord, b_irw, b_mrd, b_mwr, b_m2r, b_rw, b_srca, b_srcb, b_aluop, b_pcsrc, b_ill, b_flt, b_ret};

    always #5 clk = ~clk;

    multicycle_control_unit #(.OPCODE_W(7), .ENABLE_JAL(1'b1), .MEM_TIMEOUT(T)) dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(a_pcw), .PCWriteCond(a_pcwc), .IorD(a_iord), .IRWrite(a_irw),
        .MemRead(a_mrd), .MemWrite(a_mwr), .MemtoReg(a_m2r), .Regwrite(a_rw),
        .ALUSrcA(a_srca), .ALUSrcB(a_srcb), .ALUOp(a_aluop), .PCSource(a_pcsrc),
        .illegal_instr(a_ill), .mem_fault(a_flt), .instr_retired(a_ret), .state_o(a_st)
    );

    multicycle_control_unit #(.OPCODE_W(7), .ENABLE_JAL(1'b0), .MEM_TIMEOUT(T)) dut_nj (
        .clk(clk), .reset(reset), .Opcode(Opcode), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(b_pcw), .PCWriteCond(b_pcwc), .IorD(b_iord), .IRWrite(b_irw),
        .MemRead(b_mrd), .MemWrite(b_mwr), .MemtoReg(b_m2r), .Regwrite(b_rw),
        .ALUSrcA(b_srca), .ALUSrcB(b_srcb), .ALUOp(b_aluop), .PCSource(b_pcsrc),
        .illegal_instr(b_ill), .mem_fault(b_flt), .instr_retired(b_ret), .state_o(b_st)
    );

    typedef struct {
        logic        rdy;
        logic        z;
        logic [6:0]  op;
        logic [3:0]  sa;
        logic [16:0] oa;
        logic [3:0]  sb;
        logic [16:0] ob;
    } step_t;

    step_t q[$];
    int    errors = 0;
    int    checks = 0;
    bit    m_ill = 1'b0;
    bit    m_flt = 1'b0;
    bit    b_dead = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // Strobe set the unit should show for a given phase.
    function automatic logic [16:0] outv(input int st, input logic rdy, input logic ill, input logic flt);
        logic pcw, pcwc, iord, irw, mrd, mwr, m2r, rw, srca, pcsrc, ret;
        logic [1:0] srcb, aluop;
        {pcw, pcwc, iord, irw, mrd, mwr, m2r, rw, srca, pcsrc, ret} = '0;
        srcb  = 2'b00;
        aluop = 2'b00;
        case (st)
            S_FETCH:    begin mrd = 1; srcb = 2'b01; pcw = rdy; irw = rdy; end
            S_DECODE:   begin srcb = 2'b10; end
            S_MEM_ADDR: begin srca = 1; srcb = 2'b10; end
            S_MEM_RD:   begin iord = 1; mrd = 1; end
            S_WB_MEM:   begin rw = 1; m2r = 1; ret = 1; end
            S_MEM_WR:   begin iord = 1; mwr = 1; ret = rdy; end
            S_EXEC_R:   begin srca = 1; aluop = 2'b10; end
            S_EXEC_I:   begin srca = 1; srcb = 2'b10; end
            S_WB_ALU:   begin rw = 1; ret = 1; end
            S_BRANCH:   begin srca = 1; aluop = 2'b01; pcwc = 1; pcsrc = 1; ret = 1; end
            S_JUMP:     begin rw = 1; pcw = 1; pcsrc = 1; ret = 1; end
            default:    ;
        endcase
        return {pcw, pcwc, iord, irw, mrd, mwr, m2r, rw, srca, srcb, aluop, pcsrc, ill, flt, ret};
    endfunction

    task automatic push(input int st, input logic rdy, input logic [6:0] op);
        step_t s;
        s.rdy = rdy;
        s.z   = 1'($urandom_range(0, 1));
        s.op  = op;
        s.sa  = 4'(st);
        s.oa  = outv(st, rdy, m_ill, m_flt);
        if (b_dead) begin
            s.sb = 4'(S_TRAP);
            s.ob = outv(S_TRAP, rdy, 1'b1, 1'b0);
        end else begin
            s.sb = s.sa;
            s.ob = s.oa;
        end
        q.push_back(s);
    endtask

    // lat idle cycles then ready; lat >= T means the access never completes in time.
    task automatic wait_phase(input int st, input int lat, input logic [6:0] op, output bit ok);
        int n;
        n = (lat < T) ? lat : T;
        for (int i = 0; i < n; i++) push(st, 1'b0, op);
        if (lat >= T) begin
            m_flt = 1'b1;
            ok = 1'b0;
        end else begin
            push(st, 1'b1, op);
            ok = 1'b1;
        end
    endtask

    task automatic trap_hold(input int n);
        for (int i = 0; i < n; i++) push(S_TRAP, 1'($urandom_range(0, 1)), 7'($urandom));
    endtask

    task automatic plan(input logic [6:0] op, input int fl, input int ml, output bit trapped);
        bit ok;
        trapped = 1'b0;
        wait_phase(S_FETCH, fl, 7'($urandom), ok);
        if (!ok) begin
            trapped = 1'b1;
        end else begin
            push(S_DECODE, 1'($urandom_range(0, 1)), op);
            case (op)
                OP_R:  begin push(S_EXEC_R, 1'($urandom_range(0, 1)), op); push(S_WB_ALU, 1'($urandom_range(0, 1)), op); end
                OP_I:  begin push(S_EXEC_I, 1'($urandom_range(0, 1)), op); push(S_WB_ALU, 1'($urandom_range(0, 1)), op); end
                OP_LD: begin
                    push(S_MEM_ADDR, 1'($urandom_range(0, 1)), op);
                    wait_phase(S_MEM_RD, ml, op, ok);
                    if (ok) push(S_WB_MEM, 1'($urandom_range(0, 1)), op);
                    else trapped = 1'b1;
                end
                OP_SD: begin
                    push(S_MEM_ADDR, 1'($urandom_range(0, 1)), op);
                    wait_phase(S_MEM_WR, ml, op, ok);
                    if (!ok) trapped = 1'b1;
                end
                OP_BR:  push(S_BRANCH, 1'($urandom_range(0, 1)), op);
                OP_JAL: begin b_dead = 1'b1; push(S_JUMP, 1'($urandom_range(0, 1)), op); end
                default: begin m_ill = 1'b1; trapped = 1'b1; end
            endcase
        end
        if (trapped) trap_hold(3);
    endtask

    task automatic play();
        step_t s;
        while (q.size() > 0) begin
            s = q.pop_front();
            @(negedge clk);
            reset     = 1'b0;
            mem_ready = s.rdy;
            zero      = s.z;
            Opcode    = s.op;
            #1;
            check_val("state_jal", 32'(a_st), 32'(s.sa));
            check_val("outs_jal", 32'(va), 32'(s.oa));
            check_val("state_nojal", 32'(b_st), 32'(s.sb));
            check_val("outs_nojal", 32'(vb), 32'(s.ob));
        end
    endtask

    // Leaves reset asserted; the next played step releases it.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        mem_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        #1;
        check_val("reset_state", 32'({a_st, b_st}), 32'(0));
        check_val("reset_outs", 32'({va, vb}), 32'(0));
        m_ill  = 1'b0;
        m_flt  = 1'b0;
        b_dead = 1'b0;
        q.delete();
    endtask

    function automatic bit known_op(input logic [6:0] op);
        return (op == OP_R) || (op == OP_I) || (op == OP_LD) || (op == OP_SD) || (op == OP_BR) || (op == OP_JAL);
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit tr;
        logic [6:0] op;
        int fl, ml, k;

        do_reset();

        plan(OP_I, 0, 0, tr);  play();
        plan(OP_LD, 0, 3, tr); play();
        plan(OP_BR, 0, 0, tr); plan(OP_BR, 0, 0, tr); play();
        plan(OP_R, 1, 0, tr);  play();
        plan(OP_SD, 2, 1, tr); play();

        // illegal opcode holds TRAP for 10 cycles
        plan(7'b1111111, 0, 0, tr); trap_hold(7); play();
        do_reset();

        // jal: one instance jumps, the other traps and stays there
        plan(OP_JAL, 0, 0, tr);
        for (int i = 0; i < 3; i++) plan(OP_I, 0, 0, tr);
        play();
        do_reset();

        // fetch timeout boundary
        plan(OP_I, T, 0, tr); play();
        do_reset();
        plan(OP_I, T - 1, 0, tr); play();
        plan(OP_LD, 0, T, tr); play();
        do_reset();
        plan(OP_SD, 0, T - 1, tr); play();

        // reset during MEM_WR with mem_ready high: no retire pulse
        plan(OP_SD, 0, 6, tr);
        while (q.size() > 4) void'(q.pop_back());
        play();
        @(negedge clk);
        reset = 1'b1;
        mem_ready = 1'b1;
        #1;
        check_val("retire_in_reset", 32'(a_ret), 32'(0));
        check_val("memwrite_in_reset", 32'(a_mwr), 32'(0));
        @(negedge clk);
        #1;
        check_val("state_after_reset", 32'(a_st), 32'(S_FETCH));
        m_ill = 1'b0; m_flt = 1'b0; b_dead = 1'b0;

        for (int n = 0; n < 200; n++) begin
            k = int'($urandom_range(0, 15));
            case (k / 3)
                0: op = OP_R;
                1: op = OP_I;
                2: op = OP_LD;
                3: op = OP_SD;
                default: op = OP_BR;
            endcase
            if (k == 15) begin
                op = 7'($urandom);
                while (known_op(op)) op = 7'($urandom);
            end
            fl = ($urandom_range(0, 15) == 0) ? T : int'($urandom_range(0, T - 1));
            ml = ($urandom_range(0, 15) == 0) ? T + 1 : int'($urandom_range(0, T - 1));
            plan(op, fl, ml, tr);
            play();
            if (tr) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
